mem_access_ctrl: RTL and testbench

Sequencer directly upstream of the 8-word memory's 3-bit address decoder. It accepts single or burst read/write requests over a valid/ready handshake and drives the decoder's address and select inputs, plus the memory write-enable and write data. Each beat runs a fixed setup/strobe/hold sequence so that address is stable around the select pulse. Read data is captured and returned.

---
 rtl/mem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Burst sequencer for an 8-word memory: each beat runs SETUP/STROBE/HOLD so the address is stable around select.
// Optional MEM_CTRL_BOUNDS_CHECK_EN rejects bursts that would run past word 7 (done+err, no access).
module mem_access_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] address,
  output logic              select,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t              state, state_nxt;
  logic                write_q, write_nxt;
  logic [2:0]          remaining, remaining_nxt;
  logic [ADDR_W-1:0]   address_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;
  logic                select_nxt, mem_we_nxt, wr_ready_nxt, rd_valid_nxt, done_nxt;

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  logic              err_nxt;
  logic [ADDR_W:0]   span;
  assign span = (ADDR_W+1)'(req_addr) + (ADDR_W+1)'(req_len);
`endif

  assign req_ready = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    write_nxt     = write_q;
    remaining_nxt = remaining;
    address_nxt   = address;
    mem_wdata_nxt = mem_wdata;
    rd_valid_nxt  = 1'b0;
    done_nxt      = 1'b0;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
    err_nxt       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          write_nxt     = req_write;
          address_nxt   = req_addr;
          remaining_nxt = req_len;
          state_nxt     = SETUP;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
          // Out-of-range burst: skip every beat and report through HOLD's exit path.
          if (span > (ADDR_W+1)'((1 << ADDR_W) - 1)) begin
            remaining_nxt = 3'd0;
            state_nxt     = HOLD;
            done_nxt      = 1'b1;
            err_nxt       = 1'b1;
          end
`endif
        end
      end
      SETUP: begin
        if (!write_q) begin
          state_nxt = STROBE;
        end else if (wr_ready && wr_valid) begin
          mem_wdata_nxt = wr_data;
          state_nxt     = STROBE;
        end
      end
      STROBE: begin
        state_nxt    = HOLD;
        rd_valid_nxt = !write_q;
        done_nxt     = (remaining == 3'd0);
      end
      HOLD: begin
        if (remaining == 3'd0) begin
          state_nxt = IDLE;
        end else begin
          remaining_nxt = remaining - 3'd1;
          address_nxt   = address + ADDR_W'(1);
          state_nxt     = SETUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Decoder-facing strobes are registered from the next state so they are glitch-free.
    select_nxt   = (state_nxt == STROBE);
    mem_we_nxt   = select_nxt && write_nxt;
    wr_ready_nxt = (state_nxt == SETUP) && write_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      remaining <= 3'd0;
      address   <= '0;
      mem_wdata <= '0;
      select    <= 1'b0;
      mem_we    <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      write_q   <= write_nxt;
      remaining <= remaining_nxt;
      address   <= address_nxt;
      mem_wdata <= mem_wdata_nxt;
      select    <= select_nxt;
      mem_we    <= mem_we_nxt;
      wr_ready  <= wr_ready_nxt;
      rd_valid  <= rd_valid_nxt;
      done      <= done_nxt;
      if (state == STROBE && !write_q) begin
        rd_data <= mem_rdata;
      end
    end
  end

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= err_nxt;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver issues bursts and queues expected strobes/reads/dones
// (with cycle stamps) from a plain array memory model; a negedge monitor pops and compares.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [2:0] req_len = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       err;
  logic [2:0] address;
  logic       select;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .address(address), .select(select), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory the DUT talks to, and the independent model the expectations come from.
  logic [7:0] tb_mem [8];
  logic [7:0] ref_mem [8];
  assign mem_rdata = tb_mem[address];
  always @(posedge clk) if (select && mem_we) tb_mem[address] = mem_wdata;

  typedef struct { logic [2:0] addr; logic we; logic [7:0] wdata; int cyc; } strobe_t;
  typedef struct { logic [7:0] data; int cyc; } rd_t;
  typedef struct { logic err; int cyc; } done_t;

  strobe_t sq[$];
  rd_t     rq[$];
  done_t   dq[$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit prev_sel = 1'b0;
  bit prev_keep = 1'b0;
  int prev_done = 0;
  logic [7:0] bdata [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string what);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", what, cyc);
  endtask

  strobe_t se;
  rd_t     re;
  done_t   de;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("we_outside_strobe", 32'(mem_we && !select), 0);
      chk("err_without_done", 32'(err && !done), 0);
      if (select) begin
        chk("select_one_cycle", 32'(prev_sel), 0);
        if (sq.size() == 0) fail_event("unexpected_strobe");
        else begin
          se = sq.pop_front();
          chk("strobe_addr", 32'(address), 32'(se.addr));
          chk("strobe_we", 32'(mem_we), 32'(se.we));
          if (se.we) chk("strobe_wdata", 32'(mem_wdata), 32'(se.wdata));
          chk("strobe_cycle", cyc, se.cyc);
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) fail_event("unexpected_rd_valid");
        else begin
          re = rq.pop_front();
          chk("rd_data", 32'(rd_data), 32'(re.data));
          chk("rd_cycle", cyc, re.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) fail_event("unexpected_done");
        else begin
          de = dq.pop_front();
          chk("done_err", 32'(err), 32'(de.err));
          chk("done_cycle", cyc, de.cyc);
        end
      end
    end
    prev_sel = select;
  end

  task automatic run_burst(input bit wr, input logic [2:0] a, input logic [2:0] l, input bit keep,
                           input int stall_beat, input int stall_n, input int abort_beat);
    int a_cyc, beats, nexec, i, stalls, last_cyc, sc;
    bit oob, got;
    logic [2:0] ad;
    strobe_t s;
    beats = int'(l) + 1;
    oob = 1'b0;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
    oob = (int'(a) + int'(l) > 7);
`endif
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (req_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      fail_event("req_ready_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    a_cyc = cyc;
    if (!keep) req_valid = 1'b0;
    if (prev_keep) chk("b2b_accept_cycle", a_cyc, prev_done + 2);
    nexec = oob ? 0 : ((abort_beat >= 0) ? abort_beat + 1 : beats);
    last_cyc = a_cyc;
    for (int b = 0; b < nexec; b++) begin
      ad = a + 3'(b);
      sc = a_cyc + 1 + 3 * b + ((wr && b >= stall_beat) ? stall_n : 0);
      s.addr = ad; s.we = wr; s.wdata = wr ? bdata[b] : 8'd0; s.cyc = sc;
      sq.push_back(s);
      if (wr) ref_mem[ad] = bdata[b];
      else rq.push_back('{data: ref_mem[ad], cyc: sc + 1});
      last_cyc = sc;
    end
    if (abort_beat >= 0) prev_keep = 1'b0;
    else begin
      if (oob) dq.push_back('{err: 1'b1, cyc: a_cyc});
      else dq.push_back('{err: 1'b0, cyc: last_cyc + 1});
      prev_done = oob ? a_cyc : last_cyc + 1;
      prev_keep = keep;
    end
    if (wr && nexec > 0) begin
      i = 0;
      stalls = 0;
      for (int k = 0; k < 300 && i < nexec; k++) begin
        @(negedge clk);
        if (wr_ready) begin
          if (i == stall_beat && stalls < stall_n) begin
            wr_valid = 1'b0;
            stalls++;
          end else begin
            wr_valid = 1'b1;
            wr_data = bdata[i];
            i++;
          end
        end
      end
      if (i < nexec) fail_event("wr_ready_timeout");
    end
    if (abort_beat >= 0) begin
      @(negedge clk);
      wr_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_select", 32'(select), 0);
      chk("abort_mem_we", 32'(mem_we), 0);
      chk("abort_req_ready", 32'(req_ready), 1);
      chk("abort_done", 32'(done), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_pending_strobes", sq.size(), 0);
      chk("abort_pending_dones", dq.size(), 0);
    end
  endtask

  initial begin
    logic [2:0] ra, rl;
    bit rw, rk;
    int sb, sn, waited;
    for (int k = 0; k < 8; k++) begin
      tb_mem[k] = 8'($urandom);
      ref_mem[k] = tb_mem[k];
    end
    tb_mem[5] = 8'hA5;
    ref_mem[5] = 8'hA5;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_select", 32'(select), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    mon_en = 1'b1;

    run_burst(1'b0, 3'd5, 3'd0, 1'b0, 0, 0, -1);
    bdata[0] = 8'h11; bdata[1] = 8'h22; bdata[2] = 8'h33; bdata[3] = 8'h44;
    run_burst(1'b1, 3'd2, 3'd3, 1'b0, 0, 0, -1);
    for (int k = 0; k < 8; k++) bdata[k] = 8'($urandom);
    run_burst(1'b1, 3'd1, 3'd3, 1'b0, 1, 4, -1);
    run_burst(1'b0, 3'd6, 3'd3, 1'b0, 0, 0, -1);
    for (int k = 0; k < 8; k++) bdata[k] = 8'($urandom);
    run_burst(1'b1, 3'd0, 3'd3, 1'b0, 0, 0, 1);
    run_burst(1'b0, 3'd0, 3'd1, 1'b1, 0, 0, -1);
    for (int k = 0; k < 8; k++) bdata[k] = 8'($urandom);
    run_burst(1'b1, 3'd3, 3'd2, 1'b1, 0, 0, -1);
    run_burst(1'b0, 3'd3, 3'd2, 1'b0, 0, 0, -1);

    for (int it = 0; it < 40; it++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 3'($urandom_range(0, 7));
      rl = 3'($urandom_range(0, 7));
      rk = (it < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      sb = $urandom_range(0, int'(rl));
      sn = $urandom_range(0, 3);
      for (int k = 0; k < 8; k++) bdata[k] = 8'($urandom);
      run_burst(rw, ra, rl, rk, sb, sn, -1);
    end

    waited = 0;
    while ((sq.size() != 0 || rq.size() != 0 || dq.size() != 0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (5) @(negedge clk);
    chk("final_strobe_queue", sq.size(), 0);
    chk("final_rd_queue", rq.size(), 0);
    chk("final_done_queue", dq.size(), 0);
    for (int k = 0; k < 8; k++) chk("final_mem_word", 32'(tb_mem[k]), 32'(ref_mem[k]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
